// File: rtl/nc_mash_gen.sv
// ---------------------------------------------------------------------------
// nc_mash_gen -- MASH 1-1-...-1 noise-cancelling delta-sigma modulator core
//
// Produces a signed multibit divider-offset word for a fractional-N divider.
// Up to P_MAX_ORDER first-order error-feedback accumulators are chained. The
// active order is selected at run time. Their carries are combined by the
// noise-cancellation network (NCL) into o_y. The LSB of stage 1 can be
// dithered by a 23-bit LFSR (x^23 + x^18 + 1).
//
// Ports:
//   i_clk        clock, all state updates on the rising edge
//   i_rst        synchronous active-high reset
//   i_en         modulator step enable (one step per enabled edge)
//   i_load       capture i_frac / i_order at this edge
//   i_frac       unsigned fractional input F (P_DATA_WIDTH bits)
//   i_order      requested order minus 1, clamped to P_MAX_ORDER-1
//   i_dither_en  add the LFSR bit to the stage-1 LSB
//   o_y          signed two's-complement modulator output
//   o_valid      o_y was updated at the last edge
//   o_order      active order minus 1
//
// Output handshake: o_valid is high for exactly the one cycle after each
// enabled edge, and o_y is then the new sample. There is no ready and no
// backpressure. The consumer must take o_y in every cycle with o_valid high.
// While o_valid is low, o_y holds the last sample.
// ---------------------------------------------------------------------------
module nc_mash_gen #(
    parameter int P_DATA_WIDTH = 16,
    parameter int P_MAX_ORDER  = 4,
    parameter int P_OUT_WIDTH  = 5
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_en,
    input  logic                    i_load,
    input  logic [P_DATA_WIDTH-1:0] i_frac,
    input  logic [1:0]              i_order,
    input  logic                    i_dither_en,
    output logic [P_OUT_WIDTH-1:0]  o_y,
    output logic                    o_valid,
    output logic [1:0]              o_order
);

    localparam int         W          = P_DATA_WIDTH;
    localparam int         N          = P_MAX_ORDER;
    localparam logic [1:0] MAX_ORD_M1 = 2'(N - 1);

    // Registered state
    logic [W-1:0]           frac_r;
    logic [1:0]             order_r;
    logic [W-1:0]           acc_r    [N];
    logic [P_OUT_WIDTH-1:0] e_hist_r [N];   // e_k[n-1] for each stage
    logic [22:0]            lfsr_r;

    // Combinational step results
    logic [W-1:0]           acc_nxt [N];
    logic [N-1:0]           carry;
    logic [P_OUT_WIDTH-1:0] e_nxt   [N];
    logic [22:0]            lfsr_nxt;
    logic                   dither_bit;
    logic [1:0]             load_order;
    logic                   order_change;

    assign o_order    = order_r;
    assign dither_bit = i_dither_en & lfsr_r[0];
    assign lfsr_nxt   = {lfsr_r[21:0], lfsr_r[22] ^ lfsr_r[17]};
    assign load_order = (i_order > MAX_ORD_M1) ? MAX_ORD_M1 : i_order;

    // A reload with a different order changes the structure of the NCL, so
    // old accumulator and history state is not valid for it and is cleared.
    assign order_change = i_load && (load_order != order_r);

    // Accumulator chain. Stage 1 adds frac_r and the dither bit together in
    // one (W+1)-bit add. F = 2^W-1 with the dither bit therefore wraps and
    // produces the carry without extra logic. Stages above the active order
    // stay at zero and give no carry.
    always_comb begin
        logic [W:0]   sum;
        logic [W-1:0] prev;
        logic [W-1:0] addend;
        logic         cin;
        sum    = '0;
        prev   = '0;
        addend = '0;
        cin    = 1'b0;
        carry  = '0;
        for (int k = 0; k < N; k++) begin
            acc_nxt[k] = '0;
            if (k <= int'(order_r)) begin
                addend     = (k == 0) ? frac_r : prev;
                cin        = (k == 0) ? dither_bit : 1'b0;
                sum        = {1'b0, acc_r[k]} + {1'b0, addend} + {{W{1'b0}}, cin};
                acc_nxt[k] = sum[W-1:0];
                carry[k]   = sum[W];
                prev       = sum[W-1:0];
            end
        end
    end

    // Noise-cancellation network, evaluated from the top active stage down:
    //   e_K = c_K,  e_k = c_k + e_{k+1}[n] - e_{k+1}[n-1]
    // Inactive stages contribute 0. Wrapping modulo 2^P_OUT_WIDTH gives the
    // correct two's-complement result, because the true range fits.
    always_comb begin
        logic [P_OUT_WIDTH-1:0] e_above;
        logic [P_OUT_WIDTH-1:0] hist_above;
        e_above    = '0;
        hist_above = '0;
        for (int k = N - 1; k >= 0; k--) begin
            e_nxt[k] = '0;
            if (k <= int'(order_r)) begin
                e_nxt[k] = {{(P_OUT_WIDTH-1){1'b0}}, carry[k]} + e_above - hist_above;
            end
            e_above    = e_nxt[k];
            hist_above = (k <= int'(order_r)) ? e_hist_r[k] : '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            frac_r  <= '0;
            order_r <= '0;
            lfsr_r  <= 23'h1;
            o_y     <= '0;
            o_valid <= 1'b0;
            for (int k = 0; k < N; k++) begin
                acc_r[k]    <= '0;
                e_hist_r[k] <= '0;
            end
        end else begin
            // The step always uses the frac/order from before this edge.
            if (i_en) begin
                for (int k = 0; k < N; k++) begin
                    acc_r[k]    <= acc_nxt[k];
                    e_hist_r[k] <= e_nxt[k];
                end
                lfsr_r <= lfsr_nxt;
                o_y    <= e_nxt[0];
            end
            o_valid <= i_en;

            if (i_load) begin
                frac_r  <= i_frac;
                order_r <= load_order;
            end

            // Placed after the step update so that an order change wins.
            if (order_change) begin
                for (int k = 0; k < N; k++) begin
                    acc_r[k]    <= '0;
                    e_hist_r[k] <= '0;
                end
            end
        end
    end

endmodule

// File: doc/nc_mash_gen.md
Name: nc_mash_gen

Overview:
- Parametrised MASH 1-1-…-1 noise-cancelling delta-sigma modulator core for the fractional-N divider path.
- Stage count is selectable at run time from 1 to P_MAX_ORDER. Each stage is a first-order error-feedback accumulator.
- A noise-cancellation network combines the stage carries into a signed multibit divider-offset word, registered and flagged valid.
- Adds optional LFSR LSB dither and an atomic frac/order load, which earlier fixed 4-stage chains lack.

Parameters:
- P_DATA_WIDTH, 16, fractional word / accumulator width W (legal range 4..32).
- P_MAX_ORDER, 4, number of instantiated stages (legal range 1..4).
- P_OUT_WIDTH, 5, signed output width; must hold the range -(2^(K-1)-1)..2^(K-1) for K = P_MAX_ORDER.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_en  in  1  modulator step enable; one step per cycle while high.
- i_load  in  1  capture i_frac / i_order this cycle.
- i_frac  in  P_DATA_WIDTH  unsigned fractional input F.
- i_order  in  2  requested order minus 1 (0 → 1st order … 3 → 4th order); clamped to P_MAX_ORDER.
- i_dither_en  in  1  add LFSR bit to the stage-1 LSB.
- o_y  out  P_OUT_WIDTH  signed two's-complement modulator output.
- o_valid  out  1  o_y updated this cycle.
- o_order  out  2  active order minus 1.

Behaviour:
- Reset (i_rst high at an edge): accumulators, carry history, frac register, o_y, o_valid and o_order clear to 0; LFSR loads 23'h1. Reset dominates i_load and i_en. Mid-run reset takes effect at the next edge; o_valid is low the following cycle.
- Load: on an edge with i_load=1, frac_r <= i_frac and order_r <= min(i_order, P_MAX_ORDER-1).
  - If the new order differs from order_r, all accumulators and NCL history clear in the same edge.
  - If the order is unchanged, accumulators are kept; only the frac changes (glitch-free retune).
  - If i_load and i_en are both high, the step uses the old frac_r/order_r; the new values apply from the next step.
- Step: on an edge with i_en=1 and K = order_r+1, for stages k = 1..K:
  - in_1 = frac_r + d, where d = LFSR bit0 if i_dither_en else 0.
  - in_k = acc_{k-1}_next for k ≥ 2.
  - acc_k_next = (acc_k + in_k) mod 2^W, and c_k = carry out of that W-bit add.
  - Stages k > K hold 0 and contribute c_k = 0.
  - The whole chain is combinational within the cycle; accumulators register at the edge.
- LFSR: 23-bit Fibonacci, x^23+x^18+1, advances only on enabled steps.
- NCL, evaluated from the carries of the same step:
  - e_K = c_K; e_k = c_k + e_{k+1}[n] - e_{k+1}[n-1] for k = K-1 down to 1.
  - o_y <= e_1.
  - Histories e_k[n-1] register per stage and update only on enabled steps.
  - Equivalent form: y = Σ (1-z^-1)^(k-1) c_k.
- Latency: o_y and o_valid update at the same edge as the step. o_valid is 1 for exactly the cycle after each enabled edge; when i_en=0, o_valid=0 and o_y holds.
- Output range for order K: -(2^(K-1)-1) ≤ o_y ≤ 2^(K-1). No saturation logic is required given the P_OUT_WIDTH rule.
- Boundaries:
  - F=0 with no dither gives o_y ≡ 0.
  - Accumulator wrap is modulo 2^W by design.
  - Adding the dither bit to F = 2^W-1 wraps and produces the stage-1 carry naturally.
- o_order reflects order_r.

Test Plan:
- W=8, K=1, no dither, F=128, reset then i_en=1 → o_y = 0,1,0,1,… starting with 0; o_valid high every cycle after the first edge.
- W=8, K=3, F=0, 100 steps → o_y = 0 throughout; assert i_rst at step 50 → o_valid=0 next cycle, all state 0.
- W=8, K=3, F=64, 256 steps from reset → Σo_y ∈ [63,66] (exactly 64 carries from stage 1); every o_y ∈ [-3,4].
- W=8, K=4, random F, 10k steps → o_y ∈ [-7,8]; o_y matches the bit-accurate reference model every cycle.
- Load order 1→3 mid-run → accumulators/history clear that edge; the next o_y is computed from zero state. Reload the same order with new F → no clear; the sequence continues from the current accumulators.
- W=8, K=2, F=0, i_dither_en=1 → nonzero o_y appears; over 4096 steps the mean ≈ 0.5/256 (±10%); the LFSR sequence matches the x^23+x^18+1 model and freezes while i_en=0.
